// File: rtl/pipelined_adder.sv
// pipelined_adder: segment-pipelined WIDTH-bit adder with valid/ready handshake; ADDER_SUB_EN adds a subtract port
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = WIDTH / SEG;
  logic [WIDTH-1:0] a_q [N];
  logic [WIDTH-1:0] b_q [N];
  logic [WIDTH-1:0] s_q [N];
  logic [N-1:0]     v_q, c_q;
  logic [WIDTH-1:0] a_p [N];
  logic [WIDTH-1:0] b_p [N];
  logic [WIDTH-1:0] s_p [N];
  logic [WIDTH-1:0] s_d [N];
  logic [N-1:0]     v_p, c_p, c_d;
  logic [SEG:0]     t [N];
  logic [WIDTH-1:0] b_in;
  logic             c_in, adv;
`ifdef ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif
  assign out_valid = v_q[N-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign sum       = s_q[N-1];
  assign cout      = c_q[N-1];
  assign ovf       = (a_q[N-1][WIDTH-1] == b_q[N-1][WIDTH-1]) && (sum[WIDTH-1] != a_q[N-1][WIDTH-1]);
  // each stage adds its own segment of the operands fed from the stage before it
  always_comb begin
    a_p[0] = a;
    b_p[0] = b_in;
    s_p[0] = '0;
    c_p[0] = c_in;
    v_p[0] = in_valid;
    for (int k = 1; k < N; k++) begin
      a_p[k] = a_q[k-1];
      b_p[k] = b_q[k-1];
      s_p[k] = s_q[k-1];
      c_p[k] = c_q[k-1];
      v_p[k] = v_q[k-1];
    end
    for (int k = 0; k < N; k++) begin
      t[k] = {1'b0, a_p[k][k*SEG +: SEG]} + {1'b0, b_p[k][k*SEG +: SEG]} + {{SEG{1'b0}}, c_p[k]};
      s_d[k] = s_p[k];
      s_d[k][k*SEG +: SEG] = t[k][SEG-1:0];
      c_d[k] = t[k][SEG];
    end
  end
  // whole pipeline advances together; data only loads with a valid beat so outputs hold across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_p;
      for (int k = 0; k < N; k++) begin
        if (v_p[k]) begin
          a_q[k] <= a_p[k];
          b_q[k] <= b_p[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: self-checking bench with queue-based reference model for pipelined_adder
module tb_pipelined_adder;
  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;
  logic        clk = 0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, cout1, ovf1;
  logic [31:0] a1, b1, sum1;
  int          n_chk = 0, n_fail = 0, n_out = 0, n_acc = 0;
  bit          mon_en = 0, stalled = 0;
  logic [34:0] held;
  res_t        q[$];
  always #5 clk = ~clk;
  pipelined_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  pipelined_adder #(.WIDTH(32), .SEG(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef ADDER_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );
  function automatic res_t model(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts);
    logic [31:0] bb;
    logic [32:0] r;
    res_t        x;
    bb = ts ? ~tb : tb;
    r = {1'b0, ta} + {1'b0, bb} + {32'd0, (ts ? 1'b1 : tc)};
    x.s = r[31:0];
    x.c = r[32];
    x.o = (ta[31] == bb[31]) && (r[31] != ta[31]);
    return x;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      stalled = 0;
    end else if (mon_en) begin
      stalled = out_valid && !out_ready;
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        n_acc++;
      end
    end
  end
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (stalled) chk("stall_hold", {29'd0, out_valid, sum, cout, ovf}, {29'd0, held});
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", {63'd0, out_valid}, 64'd0);
        else chk("result", {30'd0, sum, cout, ovf}, {30'd0, q[0]});
      end
      held = {out_valid, sum, cout, ovf};
    end
  end
  task automatic single(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts,
                        input logic [31:0] es, input logic ec, input logic eo, input int el, input string nm);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk({nm, "_lat"}, 64'(lat), 64'(el));
    chk({nm, "_sum"}, {32'd0, sum}, {32'd0, es});
    chk({nm, "_cout"}, {63'd0, cout}, {63'd0, ec});
    chk({nm, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
  endtask
  task automatic single1(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts,
                         input logic [31:0] es, input logic ec, input logic eo, input string nm);
    int lat;
    @(posedge clk); #1;
    a1 = ta; b1 = tb; cin1 = tc; sub1 = ts; in_valid1 = 1;
    @(posedge clk); #1;
    in_valid1 = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid1 && lat < 20);
    chk({nm, "_lat"}, 64'(lat), 64'd1);
    chk({nm, "_sum"}, {32'd0, sum1}, {32'd0, es});
    chk({nm, "_cout"}, {63'd0, cout1}, {63'd0, ec});
    chk({nm, "_ovf"}, {63'd0, ovf1}, {63'd0, eo});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int o0, cnt;
    rst = 1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid1", {63'd0, out_valid1}, 64'd0);
    mon_en = 1;
    single(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4, "wrap");
    single(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4, "posovf");
    single(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4, "negovf");
    single(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 4, "plain");
`ifdef ADDER_SUB_EN
    single(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4, "sub_neg");
    single(32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0, 4, "sub_pos");
`endif
    @(posedge clk); #1;
    o0 = n_out;
    for (int i = 0; i < 64; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1 chk("b2b_count", 64'(n_out - o0), 64'd64);
    for (int i = 0; i < 300; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    cnt = 0;
    while (q.size() != 0 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_count", 64'(n_out), 64'(n_acc));
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; cin = 0; in_valid = 1;
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum", {32'd0, sum}, 64'd0);
    chk("midrst_cout", {63'd0, cout}, 64'd0);
    repeat (8) @(posedge clk);
    single(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 4, "postrst");
    single1(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "n1_add");
    single1(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "n1_wrap");
`ifdef ADDER_SUB_EN
    single1(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "n1_sub_neg");
    single1(32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0, "n1_sub_pos");
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, segment-pipelined two-operand binary adder with carry-in, carry-out and signed-overflow flag, and a valid/ready handshake on both sides. Operands are split into SEG-bit segments; one segment is added per pipeline stage with the carry registered between stages, so clock rate is set by a SEG-bit ripple rather than a WIDTH-bit one. It is the datapath adder for the sort and ALU paths, replacing gate-level half/full-adder chains where WIDTH > 8 or throughput matters.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, segment width per stage; number of stages N = WIDTH/SEG (N >= 1).
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- sub  input  1  subtract select (present only with ADDER_SUB_EN).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow.

## Operation
- Stage k (0..N-1) adds bits [k*SEG +: SEG] of A and B plus the carry registered from stage k-1 (stage 0 uses cin); lower result segments and not-yet-consumed upper operand segments travel alongside in skew registers.
- Each stage holds a valid bit; no other FSM. Whole pipeline advances as one unit: advance = !out_valid || out_ready.
- in_ready = advance (combinational, no dependency on in_valid).
- Input transfer when in_valid && in_ready; when advance && !in_valid a bubble (valid=0) enters stage 0.
- Final stage: sum = assembled segments, cout = carry out of top segment, ovf = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' is the operand actually added.
- Results emerge strictly in acceptance order; no reordering, no drops.
- Arithmetic is modulo 2^WIDTH; cout and ovf are the only wider information.
- sum/cout/ovf are undefined-but-stable while out_valid=0 (implemented as holding last values); bench checks only when out_valid=1.

## Timing
- Reset: all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0; in_ready reads 1 in the first cycle after reset deasserts.
- Latency: beat accepted at edge t → out_valid=1 with its result after edge t+N (N cycles). N=1 gives a registered single-cycle adder.
- Throughput: one beat per cycle with out_ready held high.
- Backpressure: out_valid=1 && out_ready=0 → all stages hold, in_ready=0, outputs stable until taken.
- Simultaneous output take and input accept in the same cycle is legal and must not lose or duplicate a beat.
- Bubbles propagate as valid=0; they never stall the pipeline.
- rst asserted mid-operation: all in-flight beats discarded at that edge, outputs return to reset values; rst dominates in_valid.

## Configuration
- ADDER_SUB_EN defined: port sub exists and is pipelined with its beat; sub=1 computes a + ~b + 1 (cin ignored, cout=1 means no borrow), ovf computed on ~b; sub=0 behaves as add.
- ADDER_SUB_EN undefined: no sub port, no inversion logic; add only.

## Test plan
- WIDTH=32, SEG=8: a=32'hFFFF_FFFF, b=0, cin=1 → after 4 cycles sum=0, cout=1, ovf=0.
- a=32'h7FFF_FFFF, b=1, cin=0 → sum=32'h8000_0000, cout=0, ovf=1; a=b=32'h8000_0000 → sum=0, cout=1, ovf=1.
- 64 random back-to-back beats, out_ready=1 → one result per cycle from cycle 4, in order, matching reference model (a+b+cin).
- Stream with out_ready toggled randomly and in_valid gaps → in_ready=0 exactly when out_valid&&!out_ready, no beat lost/duplicated, outputs stable while stalled.
- Assert rst for 1 cycle with 3 beats in flight → out_valid=0 next cycle, none of those beats ever emitted, next accepted beat appears N cycles later.
- ADDER_SUB_EN: a=5, b=7, sub=1 → sum=32'hFFFF_FFFE, cout=0; a=7, b=5, sub=1 → sum=2, cout=1; repeat at SEG=32 (N=1) for 1-cycle latency.
